ahb_wait_slave: RTL and testbench
=================================

// Module: ahb_wait_slave
// PURPOSE
// - AHB slave front-end between the AHB interconnect (HSEL_Sx decode) and a synchronous single-port SRAM macro.
// - Accepts pipelined address/data-phase transfers and inserts a configurable number of wait states.
// - Drives the SRAM strobes and returns HRead_data/HReady/HResp to the interconnect's S-side mux.
// - Rejects out-of-range accesses with a two-cycle ERROR response.
// PARAMETERS
// - ADDR_W       32     HAddress/MAddress width
// - DATA_W       32     data bus width (word = 4 bytes)
// - MEM_BYTES    65536  SRAM size in bytes; HAddress >= MEM_BYTES is out of range
// - WAIT_STATES  1      data-phase wait cycles, legal range 1..15; data phase lasts 1+WAIT_STATES cycles
// PORTS
// - clk          in   1       clock, all state on rising edge
// - rst          in   1       synchronous, active-high reset
// - HSel         in   1       slave select from interconnect decoder
// - HAddress     in   ADDR_W  address-phase byte address
// - HTrans       in   2       00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// - HWrite       in   1       1 = write transfer
// - HSize        in   3       000 byte, 001 half, 010 word
// - HWrite_data  in   DATA_W  write data, valid in data phase
// - HReady_in    in   1       global HREADY; address phase is sampled only when this is 1
// - HRead_data   out  DATA_W  read data to bus
// - HReady       out  1       0 = extend data phase
// - HResp        out  2       00 OKAY, 01 ERROR
// - MAddress     out  ADDR_W  SRAM word index = latched HAddress >> 2
// - MWrite_data  out  DATA_W  SRAM write data
// - Mwrite       out  1       SRAM write enable, qualified by Menable
// - Menable      out  1       SRAM chip enable, one-cycle pulse per transfer
// - MRead_data   in   DATA_W  SRAM read data, valid one cycle after Menable
// BEHAVIOUR
// - Reset values: HReady=1, HResp=00, HRead_data=0, MAddress=0, MWrite_data=0, Mwrite=0, Menable=0, FSM=IDLE, wait counter=0.
// - Accept condition: HSel & HReady_in & HTrans[1]. On accept, latch address, HWrite and HSize.
// - Not selected, or IDLE/BUSY transfer: zero-wait OKAY; HReady=1, HResp=00.
// - FSM states: IDLE, DATA, ERR1, ERR2.
// - IDLE -> DATA on an in-range accept.
// - IDLE -> ERR1 on an out-of-range accept.
// - DATA cycle D0: Menable=1, Mwrite=latched HWrite, MAddress=latched word index.
//   For writes, MWrite_data = HWrite_data combinationally in D0.
// - DATA cycle D1: MRead_data is valid. HRead_data passes MRead_data through and rdata_q captures it.
//   In D2 and later, HRead_data = rdata_q; rdata_q holds until the next read completes.
// - Wait counter loads WAIT_STATES at D0 and decrements each cycle.
//   HReady=0 while counter != 0; HReady=1 and HResp=00 in the final data cycle.
// - Final data cycle is also an address phase for the next transfer.
//   A new accept here goes straight to DATA/ERR1 with no idle bubble; with no accept, go to IDLE.
// - ERR1: HReady=0, HResp=01, no Menable.
// - ERR2: HReady=1, HResp=01; accepts the next address like a final data cycle.
// - Menable never asserts outside D0. The SRAM is never accessed for error or IDLE transfers.
// - HSize != word: full word is read; writes write the full word (byte lanes are the SRAM's concern).
// - Reset mid-transfer: abort. No further Menable, outputs return to reset values next cycle.
// - Address compare is unsigned and on the full ADDR_W; MEM_BYTES must be a multiple of 4.
// CONFIGURATION
// - AHB_SLV_ALIGN_CHECK_EN defined: misaligned in-range transfers take ERR1/ERR2 and are never strobed.
//   Misaligned = word with HAddress[1:0]!=0, or half with HAddress[0]!=0.
// - AHB_SLV_ALIGN_CHECK_EN undefined: HAddress[1:0] is ignored; a misaligned access proceeds on word HAddress>>2.
// TESTING
// - WAIT_STATES=1, write 0xDEADBEEF @0x10 then read @0x10:
//   each transfer has HReady low 1 cycle; Menable pulses 1 cycle with MAddress=4; read returns 0xDEADBEEF, HResp=00.
// - WAIT_STATES=3 read @0x20: HReady low exactly 3 cycles; HRead_data stable = SRAM word 8 in the final cycle.
// - Back-to-back NONSEQ reads @0x0, 0x4, 0x8:
//   new address accepted in each final data cycle; Menable pulses spaced 1+WAIT_STATES apart, no idle bubble.
// - Read @MEM_BYTES (0x10000): HReady 0 then 1 with HResp=01 both cycles; Menable never asserts.
// - IDLE/BUSY with HSel=1: HReady=1, HResp=00, no Menable.
// - rst=1 during D1 of a WAIT_STATES=3 read: next cycle HReady=1, HResp=00, Menable=0, FSM=IDLE.
// - Word write @0x12 with AHB_SLV_ALIGN_CHECK_EN defined: ERROR response, no Mwrite.
//   Same write with the macro undefined: write lands on MAddress=4.

Source files
------------

// File: rtl/ahb_wait_slave.sv
// ahb_wait_slave
//   AHB slave front-end for a synchronous single-port SRAM. Accepts pipelined
//   address/data-phase transfers, stretches every data phase by WAIT_STATES
//   cycles and answers out-of-range addresses with a two-cycle ERROR response.
//
//   Optional feature macro: AHB_SLV_ALIGN_CHECK_EN
//     defined   : misaligned in-range word/half transfers get an ERROR response
//     undefined : HAddress[1:0] ignored, access goes to word HAddress>>2
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   HSel          slave select from the interconnect decoder
//   HAddress      address-phase byte address
//   HTrans        00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HWrite        1 = write transfer
//   HSize         000 byte, 001 half, 010 word
//   HWrite_data   write data, valid during the data phase
//   HReady_in     global HREADY; address phase sampled only when high
//   HRead_data    read data to the bus
//   HReady        0 = extend data phase
//   HResp         00 OKAY, 01 ERROR
//   MAddress      SRAM word index
//   MWrite_data   SRAM write data
//   Mwrite        SRAM write enable (only with Menable)
//   Menable       SRAM chip enable, one pulse per transfer
//   MRead_data    SRAM read data, valid one cycle after Menable
module ahb_wait_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 65536,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSel,
  input  logic [ADDR_W-1:0] HAddress,
  input  logic [1:0]        HTrans,
  input  logic              HWrite,
  input  logic [2:0]        HSize,
  input  logic [DATA_W-1:0] HWrite_data,
  input  logic              HReady_in,
  output logic [DATA_W-1:0] HRead_data,
  output logic              HReady,
  output logic [1:0]        HResp,
  output logic [ADDR_W-1:0] MAddress,
  output logic [DATA_W-1:0] MWrite_data,
  output logic              Mwrite,
  output logic              Menable,
  input  logic [DATA_W-1:0] MRead_data
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } state_t;

  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [1:0]        RESP_ERROR = 2'b01;
  localparam logic [3:0]        WAIT_LOAD  = 4'(WAIT_STATES);
  // One extra bit so the limit itself is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(MEM_BYTES);

`ifdef AHB_SLV_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              hready_q;
  logic [1:0]        hresp_q;
  logic              rd_d1;      // high in the cycle after a read strobe
  logic [DATA_W-1:0] rdata_q;

  logic addr_phase;
  logic accept;
  logic out_of_range;
  logic misaligned;
  logic reject;

  always_comb begin
    // Cycles in which HReady is high double as the next address phase.
    addr_phase   = (state == IDLE) || (state == ERR2) ||
                   ((state == DATA) && (wait_cnt == '0));
    accept       = HSel && HReady_in && ((HTrans == 2'b10) || (HTrans == 2'b11));
    out_of_range = ({1'b0, HAddress} >= ADDR_LIMIT);
    misaligned   = ((HSize == 3'b010) && (HAddress[1:0] != 2'b00)) ||
                   ((HSize == 3'b001) && HAddress[0]);
    reject       = out_of_range || (ALIGN_CHECK && misaligned);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      hready_q <= 1'b1;
      hresp_q  <= RESP_OKAY;
      MAddress <= '0;
      Mwrite   <= 1'b0;
      Menable  <= 1'b0;
      rd_d1    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      Menable <= 1'b0;
      Mwrite  <= 1'b0;
      rd_d1   <= Menable && !Mwrite;
      if (rd_d1) begin
        rdata_q <= MRead_data;
      end

      if (addr_phase) begin
        if (accept && !reject) begin
          state    <= DATA;
          wait_cnt <= WAIT_LOAD;
          hready_q <= 1'b0;
          hresp_q  <= RESP_OKAY;
          MAddress <= HAddress >> 2;
          Mwrite   <= HWrite;
          Menable  <= 1'b1;
        end else if (accept) begin
          state    <= ERR1;
          hready_q <= 1'b0;
          hresp_q  <= RESP_ERROR;
        end else begin
          state    <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= RESP_OKAY;
        end
      end else begin
        case (state)
          DATA: begin
            wait_cnt <= wait_cnt - 4'd1;
            hready_q <= (wait_cnt == 4'd1);
            hresp_q  <= RESP_OKAY;
          end
          ERR1: begin
            state    <= ERR2;
            hready_q <= 1'b1;
            hresp_q  <= RESP_ERROR;
          end
          default: begin
            state    <= IDLE;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
          end
        endcase
      end
    end
  end

  assign HReady      = hready_q;
  assign HResp       = hresp_q;
  // D1 passes the SRAM output straight through; later cycles use the captured copy.
  assign HRead_data  = rd_d1 ? MRead_data : rdata_q;
  assign MWrite_data = (Menable && Mwrite) ? HWrite_data : '0;

endmodule

// File: tb/tb_ahb_wait_slave.sv
// tb_ahb_wait_slave
//   Two slaves on one bus: dut1 with WAIT_STATES=1 and dut3 with WAIT_STATES=3.
//   tgt selects which one is addressed; HReady_in is the selected slave's HReady.
//   Expected transfer results are queued when driven and compared against
//   per-data-phase observations recorded by the monitor.
module tb_ahb_wait_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSel;
  logic [31:0] HAddress;
  logic [1:0]  HTrans;
  logic        HWrite;
  logic [2:0]  HSize;
  logic [31:0] HWrite_data;
  bit          tgt;

  logic [31:0] hrd1, ma1, mwd1, mrd1, hrd3, ma3, mwd3, mrd3;
  logic [1:0]  hresp1, hresp3;
  logic        hr1, mw1, men1, hr3, mw3, men3;

  logic [31:0] hrdata, maddr, mwdata;
  logic [1:0]  hresp;
  logic        hready, men, mwrite;

  assign hready = tgt ? hr3    : hr1;
  assign hresp  = tgt ? hresp3 : hresp1;
  assign hrdata = tgt ? hrd3   : hrd1;
  assign men    = tgt ? men3   : men1;
  assign maddr  = tgt ? ma3    : ma1;
  assign mwrite = tgt ? mw3    : mw1;
  assign mwdata = tgt ? mwd3   : mwd1;

  always #5 clk = ~clk;

  ahb_wait_slave #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(65536), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .HSel(HSel && !tgt), .HAddress(HAddress), .HTrans(HTrans),
    .HWrite(HWrite), .HSize(HSize), .HWrite_data(HWrite_data), .HReady_in(hready),
    .HRead_data(hrd1), .HReady(hr1), .HResp(hresp1), .MAddress(ma1),
    .MWrite_data(mwd1), .Mwrite(mw1), .Menable(men1), .MRead_data(mrd1));

  ahb_wait_slave #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(65536), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .HSel(HSel && tgt), .HAddress(HAddress), .HTrans(HTrans),
    .HWrite(HWrite), .HSize(HSize), .HWrite_data(HWrite_data), .HReady_in(hready),
    .HRead_data(hrd3), .HReady(hr3), .HResp(hresp3), .MAddress(ma3),
    .MWrite_data(mwd3), .Mwrite(mw3), .Menable(men3), .MRead_data(mrd3));

  // SRAM models: 16K words each, preloaded with a word-index pattern.
  logic [31:0] sram1 [16384];
  logic [31:0] sram3 [16384];

  function automatic logic [31:0] pat(input int w);
    return 32'hC0DE0000 | 32'(w);
  endfunction

  always @(posedge clk) begin
    if (men1) begin
      if (mw1) sram1[ma1[13:0]] <= mwd1;
      else     mrd1 <= sram1[ma1[13:0]];
    end
    if (men3) begin
      if (mw3) sram3[ma3[13:0]] <= mwd3;
      else     mrd3 <= sram3[ma3[13:0]];
    end
  end

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] word;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  typedef struct {
    int          lows;
    int          men;
    int          men_cyc;
    logic [1:0]  resp_low;
    logic [1:0]  resp_final;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    bit          mwr;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  logic [31:0] ref1 [int];
  logic [31:0] ref3 [int];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int stray_men  = 0;
  bit mon_active = 0;
  bit mon_start  = 0;
  obs_t cur;

  // Monitor: records one observation per data phase.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_active = 0;
      mon_start  = 0;
    end else begin
      if (mon_start) begin
        mon_active = 1;
        mon_start  = 0;
        cur = '{default: '0};
      end
      if (mon_active) begin
        if (men) begin
          cur.men++;
          cur.men_cyc = cyc;
          cur.maddr   = maddr;
          cur.mwr     = mwrite;
          cur.mwdata  = mwdata;
        end
        if (!hready) begin
          cur.lows++;
          cur.resp_low = hresp;
        end else begin
          cur.resp_final = hresp;
          cur.rdata      = hrdata;
          obs_q.push_back(cur);
          mon_active = 0;
        end
      end else if (men) begin
        stray_men++;
      end
      if (HSel && hready && HTrans[1]) mon_start = 1;
    end
  end

  function automatic logic [31:0] model_read(input bit t, input int w);
    if (t) return ref3.exists(w) ? ref3[w] : pat(w);
    return ref1.exists(w) ? ref1[w] : pat(w);
  endfunction

  function automatic void push_exp(input bit wr, input logic [31:0] addr,
                                   input logic [31:0] wd, input bit err);
    exp_t e;
    int   w;
    w       = int'(addr >> 2);
    e.wr    = wr;
    e.err   = err;
    e.word  = addr >> 2;
    e.wdata = wd;
    e.waits = err ? 1 : (tgt ? 3 : 1);
    e.rdata = model_read(tgt, w);
    if (wr && !err) begin
      if (tgt) ref3[w] = wd;
      else     ref1[w] = wd;
    end
    exp_q.push_back(e);
  endfunction

  // Drive one address phase; returns once it has been accepted (or timed out).
  task automatic addr_phase(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wd, output bit ok);
    HSel = 1'b1; HAddress = addr; HTrans = 2'b10; HWrite = wr; HSize = size;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    HSel = 1'b0; HTrans = 2'b00; HWrite = 1'b0;
    if (wr) HWrite_data = wd;
  endtask

  // Wait for all queued transfers to be observed and the bus to go quiet.
  task automatic settle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= exp_q.size() && !mon_active && !mon_start) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors++; if (hr1 !== 1'b1)          begin miscompares++; $display("FAIL reset_hready1: got %b want 1", hr1); end
    vectors++; if (hresp1 !== 2'b00)      begin miscompares++; $display("FAIL reset_hresp1: got %b want 00", hresp1); end
    vectors++; if (hrd1 !== 32'h0)        begin miscompares++; $display("FAIL reset_hrdata1: got %h want 0", hrd1); end
    vectors++; if (ma1 !== 32'h0)         begin miscompares++; $display("FAIL reset_maddr1: got %h want 0", ma1); end
    vectors++; if (mwd1 !== 32'h0)        begin miscompares++; $display("FAIL reset_mwdata1: got %h want 0", mwd1); end
    vectors++; if (mw1 !== 1'b0)          begin miscompares++; $display("FAIL reset_mwrite1: got %b want 0", mw1); end
    vectors++; if (men1 !== 1'b0)         begin miscompares++; $display("FAIL reset_menable1: got %b want 0", men1); end
    vectors++; if (dut1.state !== 2'b00)  begin miscompares++; $display("FAIL reset_state1: got %b want 00", dut1.state); end
    vectors++; if (hr3 !== 1'b1)          begin miscompares++; $display("FAIL reset_hready3: got %b want 1", hr3); end
    vectors++; if (men3 !== 1'b0)         begin miscompares++; $display("FAIL reset_menable3: got %b want 0", men3); end
    vectors++; if (dut3.wait_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_waitcnt3: got %0d want 0", dut3.wait_cnt); end
  endtask

  task automatic test_write_read();
    bit ok; exp_t e; obs_t o;
    tgt = 1'b0;
    push_exp(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    addr_phase(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr_accept: got timeout want accept"); end
    settle(ok);
    push_exp(1'b0, 32'h10, 32'h0, 1'b0);
    addr_phase(1'b0, 32'h10, 3'b010, 32'h0, ok);
    settle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr_settle: got timeout want done"); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o.lows != e.waits) begin miscompares++; $display("FAIL wr_lows: got %0d want %0d", o.lows, e.waits); end
      vectors++; if (o.resp_final !== 2'b00) begin miscompares++; $display("FAIL wr_resp: got %b want 00", o.resp_final); end
      vectors++; if (o.men != 1) begin miscompares++; $display("FAIL wr_menable: got %0d pulses want 1", o.men); end
      vectors++; if (o.maddr !== 32'd4) begin miscompares++; $display("FAIL wr_maddr: got %h want 4", o.maddr); end
      vectors++; if (o.mwr !== e.wr) begin miscompares++; $display("FAIL wr_mwrite: got %b want %b", o.mwr, e.wr); end
      if (e.wr) begin
        vectors++; if (o.mwdata !== e.wdata) begin miscompares++; $display("FAIL wr_mwdata: got %h want %h", o.mwdata, e.wdata); end
      end else begin
        vectors++; if (o.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_rdata: got %h want deadbeef", o.rdata); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wait_states();
    bit ok; exp_t e; obs_t o;
    tgt = 1'b1;
    push_exp(1'b0, 32'h20, 32'h0, 1'b0);
    addr_phase(1'b0, 32'h20, 3'b010, 32'h0, ok);
    settle(ok);
    vectors++; if (!ok || obs_q.size() != 1) begin miscompares++; $display("FAIL ws3_done: got %0d phases want 1", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o.lows != 3) begin miscompares++; $display("FAIL ws3_lows: got %0d want 3", o.lows); end
      vectors++; if (o.resp_final !== 2'b00) begin miscompares++; $display("FAIL ws3_resp: got %b want 00", o.resp_final); end
      vectors++; if (o.men != 1 || o.maddr !== 32'd8) begin miscompares++; $display("FAIL ws3_strobe: got %0d pulses addr %h want 1 addr 8", o.men, o.maddr); end
      vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL ws3_rdata: got %h want %h", o.rdata, e.rdata); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok; exp_t e; obs_t o; int prev; int n;
    for (int t = 0; t < 2; t++) begin
      tgt = (t == 1);
      for (int k = 0; k < 3; k++) push_exp(1'b0, 32'(k * 4), 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) addr_phase(1'b0, 32'(k * 4), 3'b010, 32'h0, ok);
      settle(ok);
      vectors++; if (!ok || obs_q.size() != 3) begin miscompares++; $display("FAIL b2b_done t%0d: got %0d phases want 3", t, obs_q.size()); end
      prev = -1; n = 0;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        vectors++; if (o.lows != e.waits) begin miscompares++; $display("FAIL b2b_lows t%0d #%0d: got %0d want %0d", t, n, o.lows, e.waits); end
        vectors++; if (o.men != 1 || o.maddr !== e.word) begin miscompares++; $display("FAIL b2b_strobe t%0d #%0d: got %0d pulses addr %h want 1 addr %h", t, n, o.men, o.maddr, e.word); end
        vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL b2b_rdata t%0d #%0d: got %h want %h", t, n, o.rdata, e.rdata); end
        if (prev >= 0) begin
          vectors++; if (o.men_cyc - prev != 1 + e.waits) begin miscompares++; $display("FAIL b2b_spacing t%0d #%0d: got %0d want %0d", t, n, o.men_cyc - prev, 1 + e.waits); end
        end
        prev = o.men_cyc; n++;
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_error();
    bit ok; exp_t e; obs_t o;
    tgt = 1'b1;
    push_exp(1'b0, 32'h10000, 32'h0, 1'b1);
    push_exp(1'b0, 32'h20, 32'h0, 1'b0);
    addr_phase(1'b0, 32'h10000, 3'b010, 32'h0, ok);
    addr_phase(1'b0, 32'h20, 3'b010, 32'h0, ok);
    settle(ok);
    vectors++; if (!ok || obs_q.size() != 2) begin miscompares++; $display("FAIL err_done: got %0d phases want 2", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o.lows != e.waits) begin miscompares++; $display("FAIL err_lows err=%0d: got %0d want %0d", e.err, o.lows, e.waits); end
      vectors++; if (o.resp_final !== (e.err ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL err_resp err=%0d: got %b want %b", e.err, o.resp_final, e.err ? 2'b01 : 2'b00); end
      vectors++; if (o.men != (e.err ? 0 : 1)) begin miscompares++; $display("FAIL err_menable err=%0d: got %0d pulses want %0d", e.err, o.men, e.err ? 0 : 1); end
      if (e.err) begin
        vectors++; if (o.resp_low !== 2'b01) begin miscompares++; $display("FAIL err_resp_wait: got %b want 01", o.resp_low); end
      end else begin
        vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL err_next_rdata: got %h want %h", o.rdata, e.rdata); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_idle_busy();
    tgt = 1'b0;
    HSel = 1'b1; HAddress = 32'h40;
    for (int i = 0; i < 4; i++) begin
      HTrans = (i < 2) ? 2'b00 : 2'b01;
      @(negedge clk);
      vectors++; if (hready !== 1'b1 || hresp !== 2'b00 || men !== 1'b0) begin miscompares++; $display("FAIL idle_busy cyc%0d: got ready=%b resp=%b men=%b want 1 00 0", i, hready, hresp, men); end
      @(posedge clk); #1;
    end
    HSel = 1'b0; HTrans = 2'b00;
    @(negedge clk);
    vectors++; if (stray_men != 0) begin miscompares++; $display("FAIL stray_menable: got %0d want 0", stray_men); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    bit ok; bit err; exp_t e; obs_t o;
    tgt = 1'b0;
`ifdef AHB_SLV_ALIGN_CHECK_EN
    err = 1'b1;
`else
    err = 1'b0;
`endif
    push_exp(1'b1, 32'h12, 32'h12345678, err);
    addr_phase(1'b1, 32'h12, 3'b010, 32'h12345678, ok);
    settle(ok);
    push_exp(1'b0, 32'h10, 32'h0, 1'b0);
    addr_phase(1'b0, 32'h10, 3'b010, 32'h0, ok);
    settle(ok);
    vectors++; if (!ok || obs_q.size() != 2) begin miscompares++; $display("FAIL mis_done: got %0d phases want 2", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o.resp_final !== (e.err ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL mis_resp wr=%0d: got %b want %b", e.wr, o.resp_final, e.err ? 2'b01 : 2'b00); end
      vectors++; if (o.men != (e.err ? 0 : 1)) begin miscompares++; $display("FAIL mis_menable wr=%0d: got %0d pulses want %0d", e.wr, o.men, e.err ? 0 : 1); end
      if (e.wr && !e.err) begin
        vectors++; if (o.maddr !== 32'd4 || o.mwr !== 1'b1) begin miscompares++; $display("FAIL mis_write: got addr %h wr %b want 4 1", o.maddr, o.mwr); end
      end
      if (!e.wr) begin
        vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL mis_readback: got %h want %h", o.rdata, e.rdata); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_abort();
    bit ok;
    tgt = 1'b1;
    addr_phase(1'b0, 32'h20, 3'b010, 32'h0, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (hr3 !== 1'b1 || hresp3 !== 2'b00) begin miscompares++; $display("FAIL abort_resp: got ready=%b resp=%b want 1 00", hr3, hresp3); end
    vectors++; if (dut3.state !== 2'b00) begin miscompares++; $display("FAIL abort_state: got %b want 00", dut3.state); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (men3 !== 1'b0 || hr3 !== 1'b1) begin miscompares++; $display("FAIL abort_quiet cyc%0d: got men=%b ready=%b want 0 1", i, men3, hr3); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      sram1[i] = pat(i);
      sram3[i] = pat(i);
    end
    rst = 1'b1; tgt = 1'b0;
    HSel = 1'b0; HAddress = '0; HTrans = 2'b00; HWrite = 1'b0; HSize = 3'b010; HWrite_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    test_write_read();
    test_wait_states();
    test_back_to_back();
    test_error();
    test_idle_busy();
    test_misaligned();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
